r8_booth_encode_stage: RTL
==========================

R8_BOOTH_ENCODE_STAGE -- requirements
Module: r8_booth_encode_stage

Interface
REQ-001 The module SHALL have parameter N, default 16, the operand width in bits (N >= 4).
REQ-002 The module SHALL have derived constants G = N/3 + 1 (integer division; number of radix-8 groups) and W = N + 3 (multiple width).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the operand beat is valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the stage accepts an operand beat this cycle.
REQ-007 The module SHALL have port x_in, input, N bits: the multiplicand.
REQ-008 The module SHALL have port y_in, input, N bits: the multiplier.
REQ-009 The module SHALL have port tc_in, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-010 The module SHALL have port out_valid, output, 1 bit: the encoded beat is valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit: downstream (selector array) consumes the beat.
REQ-012 The module SHALL have ports mult1, mult2, mult3 and mult4, outputs, W bits each: the signed multiples +1X, +2X, +3X and +4X.
REQ-013 The module SHALL have port be_sel, output, 5*G bits: group g occupies bits [5g+4:5g] = {neg, sel4X, sel3X, sel2X, sel1X}.

Function
REQ-014 The stage SHALL extend X to W bits and Y to 3G bits: sign-extension when tc=1, zero-extension when tc=0.
REQ-015 mult1 SHALL be Xext, mult2 SHALL be Xext<<1, mult4 SHALL be Xext<<2, and mult3 SHALL be Xext + (Xext<<1) computed by a W-bit adder, with no overflow possible at width W.
REQ-016 Group g SHALL use bits b3..b0 = Yext[3g+2], Yext[3g+1], Yext[3g], Yext[3g-1], with Yext[-1] = 0.
REQ-017 The group digit SHALL be d = -4*b3 + 2*b2 + b1 + b0, with d in [-4, 4].
REQ-018 For each group, sel1X..sel4X SHALL be one-hot on |d| = 1..4 and all zero when d = 0.
REQ-019 For each group, neg SHALL be b3, including d = 0 with b3 = 1 (pattern 1111), which yields {1,0000}; downstream applies the +1 correction.
REQ-020 Identity: the sum over g of d_g*8^g SHALL equal Y as interpreted by tc.
REQ-021 The pipeline SHALL have two register stages:
  - S1 captures {x, y, tc}.
  - S2 holds the computed multiples and be_sel.
  - Latency from input acceptance to out_valid SHALL be 2 cycles.
REQ-022 S2 SHALL load when s1_valid && (!out_valid || out_ready).
REQ-023 S1 SHALL load when in_valid && in_ready.
REQ-024 in_ready SHALL be !s1_valid || (!out_valid || out_ready), combinational.
REQ-025 With out_ready held at 1, the stage SHALL accept one beat per cycle with no bubbles.
REQ-026 While out_valid && !out_ready, all outputs SHALL be held stable, and S1 SHALL hold its beat; one beat in S1 plus one in S2 SHALL be the maximum occupancy.
REQ-027 Simultaneous S2 consume and S1 advance in the same cycle SHALL transfer without loss or duplication.
REQ-028 Beats SHALL leave in acceptance order, with no drop or reorder.
REQ-029 out_valid SHALL NOT depend combinationally on in_valid.

Reset
REQ-030 While rst_n = 0, s1_valid and out_valid SHALL be 0 immediately, asynchronously.
REQ-031 While rst_n = 0, mult1..mult4 and be_sel SHALL be 0, and in_ready SHALL be 1.
REQ-032 Beats in flight at reset assertion SHALL be discarded.
REQ-033 After rst_n deasserts, the first beat SHALL be accepted on the first rising edge with in_valid = 1.

Verification
REQ-034 Scenario "small positive multiplier": N=16, tc=1, y=0x0007 -> group0 = 5'b10001 (d=-1), group1 = 5'b00001, groups 2..5 = 0, out_valid exactly 2 cycles after accept.
REQ-035 Scenario "most-negative vs. unsigned": y=0x8000 -> with tc=1, group5 = 5'b10001 and groups 0..4 = 0; with tc=0, group5 = 5'b00001 and groups 0..4 = 0.
REQ-036 Scenario "all-ones multiplier": tc=1, y=0xFFFF -> group0 = 5'b10001, groups 1..5 = 5'b10000; tc=1, x=0x7FFF -> mult3 = 19'h17FFD, mult4 = 19'h1FFFC.
REQ-037 Scenario "backpressure": stream 4 beats with out_ready low for 3 cycles mid-stream -> in_ready drops after 2 held beats, outputs stable while stalled, all 4 beats delivered in order.
REQ-038 Scenario "reset mid-operation": assert rst_n = 0 with 2 beats in flight -> out_valid falls asynchronously, no stale beat appears after release, next beat arrives at latency 2.
REQ-039 Scenario "random self-check": 10k random x, y, tc, out_ready -> sum(d_g*8^g) == Y and the multiples match the reference arithmetic for every delivered beat.

Source files
------------

// File: rtl/r8_booth_encode_stage.sv
// Radix-8 Booth encoding stage: registers the operands (S1), then computes
// the four signed multiples of X and the per-group Booth selects into an
// output register (S2). Valid/ready handshake on both sides.
module r8_booth_encode_stage #(
  parameter  int N = 16,
  localparam int G = N / 3 + 1,
  localparam int W = N + 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   x_in,
  input  logic [N-1:0]   y_in,
  input  logic           tc_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   mult1,
  output logic [W-1:0]   mult2,
  output logic [W-1:0]   mult3,
  output logic [W-1:0]   mult4,
  output logic [5*G-1:0] be_sel
);

  localparam int YW = 3 * G;

  // Booth group {b3,b2,b1,b0} -> {neg, sel4X, sel3X, sel2X, sel1X}.
  // 1111 encodes zero with neg set; the consumer applies the +1 correction.
  function automatic logic [4:0] booth_enc(input logic [3:0] grp);
    logic [4:0] enc;
    case (grp)
      4'b0000:          enc = 5'b00000;
      4'b0001, 4'b0010: enc = 5'b00001;
      4'b0011, 4'b0100: enc = 5'b00010;
      4'b0101, 4'b0110: enc = 5'b00100;
      4'b0111:          enc = 5'b01000;
      4'b1000:          enc = 5'b11000;
      4'b1001, 4'b1010: enc = 5'b10100;
      4'b1011, 4'b1100: enc = 5'b10010;
      4'b1101, 4'b1110: enc = 5'b10001;
      default:          enc = 5'b10000;
    endcase
    return enc;
  endfunction

  logic           s1_valid_q, s1_valid_d;
  logic [N-1:0]   x_q, x_d;
  logic [N-1:0]   y_q, y_d;
  logic           tc_q, tc_d;

  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   mult1_q, mult1_d;
  logic [W-1:0]   mult2_q, mult2_d;
  logic [W-1:0]   mult3_q, mult3_d;
  logic [W-1:0]   mult4_q, mult4_d;
  logic [5*G-1:0] be_sel_q, be_sel_d;

  logic           s1_load;
  logic           s2_load;
  logic [W-1:0]   xext;
  logic [YW-1:0]  yext;
  logic [YW:0]    ypad;
  logic [W-1:0]   m3_calc;
  logic [5*G-1:0] be_calc;

  // Handshake: S2 frees when empty or being consumed; S1 accepts when empty
  // or when its beat is advancing into S2 this cycle.
  always_comb begin
    s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !s1_valid_q || (!out_valid_q || out_ready);
    s1_load  = in_valid && in_ready;
  end

  // Operand extension, multiples and Booth group encoding from S1 contents.
  always_comb begin
    xext    = {{3{tc_q & x_q[N-1]}}, x_q};
    yext    = {{(YW-N){tc_q & y_q[N-1]}}, y_q};
    ypad    = {yext, 1'b0};
    m3_calc = xext + (xext << 1);
    be_calc = '0;
    for (int unsigned g = 0; g < G; g++) begin
      be_calc[5*g +: 5] = booth_enc(ypad[3*g +: 4]);
    end
  end

  // S1 next state: capture a new beat, or empty once its beat moves on.
  always_comb begin
    s1_valid_d = s1_valid_q;
    x_d        = x_q;
    y_d        = y_q;
    tc_d       = tc_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      x_d        = x_in;
      y_d        = y_in;
      tc_d       = tc_in;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 next state: load computed results, or drop valid once consumed.
  always_comb begin
    out_valid_d = out_valid_q;
    mult1_d     = mult1_q;
    mult2_d     = mult2_q;
    mult3_d     = mult3_q;
    mult4_d     = mult4_q;
    be_sel_d    = be_sel_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      mult1_d     = xext;
      mult2_d     = xext << 1;
      mult3_d     = m3_calc;
      mult4_d     = xext << 2;
      be_sel_d    = be_calc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      tc_q        <= 1'b0;
      out_valid_q <= 1'b0;
      mult1_q     <= '0;
      mult2_q     <= '0;
      mult3_q     <= '0;
      mult4_q     <= '0;
      be_sel_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      tc_q        <= tc_d;
      out_valid_q <= out_valid_d;
      mult1_q     <= mult1_d;
      mult2_q     <= mult2_d;
      mult3_q     <= mult3_d;
      mult4_q     <= mult4_d;
      be_sel_q    <= be_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign mult1     = mult1_q;
  assign mult2     = mult2_q;
  assign mult3     = mult3_q;
  assign mult4     = mult4_q;
  assign be_sel    = be_sel_q;

endmodule
